// File: rtl/spi_pkg.sv
// Constants and FSM encoding shared by both ends of the single-port-RAM SPI link.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StShift,
    StWait,
    StRecv,
    StEnd
  } spi_state_e;

endpackage

// File: rtl/spi_master.sv
// SPI initiator: serialises 10-bit commands on MOSI at one bit per clk and, for
// read-data commands, captures the 8-bit reply from MISO after a turnaround.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned TURN = 2,
  parameter int unsigned GAP  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  input  logic [FRAME_W-1:0] cmd_data_i,
  output logic               cmd_ready_o,
  output logic               ss_n_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic               busy_o
);

  spi_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [1:0]         code_q, code_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    code_d     = code_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q is the registered view of IDLE, low for one cycle after reset
        if (cmd_valid_i && cmd_ready_q) begin
          sreg_d  = cmd_data_i;
          code_d  = cmd_data_i[FRAME_W-1 -: 2];
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StShift;
        cnt_d   = 4'(FRAME_W - 1);
      end
      StShift: begin
        sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
        if (cnt_q == 4'd0) begin
          if (code_q == CMD_RD_DATA) begin
            state_d = StWait;
            cnt_d   = 4'(TURN - 1);
          end else begin
            state_d = StEnd;
            cnt_d   = 4'(GAP - 1);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StRecv;
          cnt_d   = 4'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecv: begin
        sreg_d = {sreg_q[FRAME_W-2:0], miso_i};
        if (cnt_q == 4'd0) begin
          rd_data_d  = {sreg_q[DATA_W-2:0], miso_i};
          rd_valid_d = 1'b1;
          state_d    = StEnd;
          cnt_d      = 4'(GAP - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StEnd: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q
    ss_n_d      = !(state_d inside {StStart, StShift, StWait, StRecv});
    mosi_d      = (state_d == StStart || state_d == StShift) ? sreg_d[FRAME_W-1] : 1'b0;
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      sreg_q      <= '0;
      code_q      <= 2'b00;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      code_q      <= code_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign ss_n_o      = ss_n_q;
  assign mosi_o      = mosi_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a frame-level model predicts every output each cycle, plus
// literal checks on MOSI streams, frame lengths and captured read bytes.
module tb_spi_master;

  localparam int unsigned TURN = 2;
  localparam int unsigned GAP  = 1;

  logic       clk_i       = 1'b0;
  logic       rst_ni      = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic [9:0] cmd_data_i  = '0;
  logic       miso_i      = 1'b0;
  logic       cmd_ready_o;
  logic       ss_n_o;
  logic       mosi_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  spi_master #(
    .TURN(TURN),
    .GAP (GAP)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_data_i (cmd_data_i),
    .cmd_ready_o(cmd_ready_o),
    .ss_n_o     (ss_n_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .busy_o     (busy_o)
  );

  // One entry per cycle of an accepted frame; an empty queue means the master is idle.
  typedef struct packed {
    logic       ss_n;
    logic       mosi;
    logic       busy;
    logic       rdv;
    logic       miso;
    logic [7:0] rd;
  } exp_t;

  exp_t       exp_q[$];
  logic       model_ready = 1'b0;
  logic [7:0] model_rd    = 8'h00;
  logic [7:0] next_byte   = 8'h00;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          fall_cyc[$];
  int          low_len = 0;
  int          rdv_cnt = 0;
  logic [31:0] mosi_cap = '0;
  logic        prev_ss  = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void build_frame(input logic [9:0] cmd, input logic [7:0] rbyte);
    exp_t e;
    e      = '0;
    e.ss_n = 1'b0;
    e.busy = 1'b1;
    e.mosi = cmd[9];
    exp_q.push_back(e);
    for (int i = 9; i >= 0; i--) begin
      e.mosi = cmd[i];
      exp_q.push_back(e);
    end
    e.mosi = 1'b0;
    if (cmd[9:8] == 2'b11) begin
      for (int i = 0; i < int'(TURN); i++) exp_q.push_back(e);
      for (int i = 7; i >= 0; i--) begin
        e.miso = rbyte[i];
        exp_q.push_back(e);
      end
      e.miso = 1'b0;
    end
    e.ss_n = 1'b1;
    for (int i = 0; i < int'(GAP); i++) begin
      e.rdv = (i == 0) && (cmd[9:8] == 2'b11);
      e.rd  = rbyte;
      exp_q.push_back(e);
    end
  endfunction

  task automatic compare();
    exp_t e;
    logic exp_ready;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
    end else begin
      e      = '0;
      e.ss_n = 1'b1;
    end
    exp_ready = (exp_q.size() == 0) && model_ready;
    chk("ss_n",      32'(ss_n_o),      32'(e.ss_n));
    chk("mosi",      32'(mosi_o),      32'(e.mosi));
    chk("busy",      32'(busy_o),      32'(e.busy));
    chk("cmd_ready", 32'(cmd_ready_o), 32'(exp_ready));
    chk("rd_valid",  32'(rd_valid_o),  32'(e.rdv));
    chk("rd_data",   32'(rd_data_o),   32'(model_rd));
    if (prev_ss && !ss_n_o) fall_cyc.push_back(cyc);
    if (!ss_n_o) begin
      low_len++;
      mosi_cap = {mosi_cap[30:0], mosi_o};
    end
    if (rd_valid_o) rdv_cnt++;
    prev_ss = ss_n_o;
    miso_i  = e.miso;
  endtask

  task automatic tick();
    exp_t d;
    @(posedge clk_i);
    cyc++;
    if (!rst_ni) begin
      exp_q.delete();
      model_ready = 1'b0;
      model_rd    = 8'h00;
    end else if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
    end else begin
      if (model_ready && cmd_valid_i) build_frame(cmd_data_i, next_byte);
      model_ready = 1'b1;
    end
    if (exp_q.size() > 0 && exp_q[0].rdv) model_rd = exp_q[0].rd;
    @(negedge clk_i);
    compare();
  endtask

  task automatic mon_clear();
    fall_cyc.delete();
    low_len  = 0;
    rdv_cnt  = 0;
    mosi_cap = '0;
  endtask

  initial begin
    // Reset with cmd_valid asserted: nothing may be accepted
    #2;
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_data_i  = 10'h3FF;
    repeat (3) tick();
    chk("rst_ready_lit", 32'(cmd_ready_o), 32'd0);
    chk("rst_ss_n_lit",  32'(ss_n_o),      32'd1);
    rst_ni      = 1'b1;
    cmd_valid_i = 1'b0;
    tick();
    chk("ready_after_release", 32'(cmd_ready_o), 32'd1);

    // Write address 00_1010_0101
    mon_clear();
    cmd_data_i  = 10'b00_1010_0101;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (20) tick();
    chk("wa_low_len", 32'(low_len),         32'd11);
    chk("wa_mosi",    mosi_cap,             32'(11'b00010100101));
    chk("wa_frames",  32'(fall_cyc.size()), 32'd1);
    chk("wa_rdv",     32'(rdv_cnt),         32'd0);

    // Write data then read address with cmd_valid held across both
    mon_clear();
    cmd_data_i  = 10'h13C;
    cmd_valid_i = 1'b1;
    tick();
    cmd_data_i  = 10'h23C;
    repeat (13) tick();
    cmd_valid_i = 1'b0;
    repeat (20) tick();
    chk("b2b_frames",  32'(fall_cyc.size()), 32'd2);
    if (fall_cyc.size() >= 2) chk("b2b_fall_to_fall", 32'(fall_cyc[1] - fall_cyc[0]), 32'd13);
    chk("b2b_low_len", 32'(low_len), 32'd22);
    chk("b2b_mosi",    mosi_cap,     32'({11'b00100111100, 11'b11000111100}));

    // Read data aborted by reset after four MISO samples
    mon_clear();
    next_byte   = 8'hA5;
    cmd_data_i  = 10'h300;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (17) tick();
    rst_ni = 1'b0;
    #1;
    chk("abort_ss_n_async", 32'(ss_n_o), 32'd1);
    chk("abort_busy_async", 32'(busy_o), 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (4) tick();
    chk("abort_rdv",     32'(rdv_cnt),   32'd0);
    chk("abort_rd_data", 32'(rd_data_o), 32'h00);

    // Read data returning C3
    mon_clear();
    next_byte   = 8'hC3;
    cmd_data_i  = 10'h300;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (30) tick();
    chk("rd_low_len", 32'(low_len),   32'd21);
    chk("rd_data",    32'(rd_data_o), 32'hC3);
    chk("rd_pulses",  32'(rdv_cnt),   32'd1);

    // Command offered mid-frame must be dropped
    mon_clear();
    cmd_data_i  = 10'h0A5;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (4) tick();
    cmd_data_i  = 10'h1FF;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (20) tick();
    chk("busy_frames",  32'(fall_cyc.size()), 32'd1);
    chk("busy_low_len", 32'(low_len),         32'd11);
    chk("busy_mosi",    mosi_cap,             32'(11'b00010100101));
    chk("busy_rd_data", 32'(rd_data_o),       32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
